operand_entry: RTL and testbench

//   Front-end key stage of the integer calculator. Conditions the raw digit

---
 rtl/operand_entry.sv | 160 ++++++++++++++++
 tb/tb_operand_entry.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// Key-entry front end: debounces digit/operator switches, builds decimal operands
// and streams {operand, operator} tokens over a valid/ready handshake.
module operand_entry #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned MAX_DIGITS = 4,
   parameter int unsigned DB_CYCLES  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [9:0]              dig_key,
   input  logic [7:0]              op_key,
   output logic                    tok_valid,
   input  logic                    tok_ready,
   output logic                    tok_is_op,
   output logic [WIDTH-1:0]        tok_num,
   output logic [2:0]              tok_op,
   output logic [4*MAX_DIGITS-1:0] entry_bcd,
   output logic [2:0]              entry_cnt,
   output logic                    ovf_pulse,
   output logic                    drop_pulse
);

   localparam int unsigned NK = 18;
   localparam int unsigned CW = $clog2(DB_CYCLES + 1);
   localparam int unsigned MW = WIDTH + 4;
   localparam int unsigned BW = 4 * MAX_DIGITS;

   typedef enum logic [1:0] {IDLE, ENTRY, SEND_NUM, SEND_OP} state_t;

   logic [NK-1:0] key_raw;
   logic [NK-1:0] sync1_q, sync2_q, flt_q, evt_q;
   logic [CW-1:0] db_cnt_q [NK];

   state_t           state_q;
   logic [WIDTH-1:0] value_q;
   logic [BW-1:0]    bcd_q;
   logic [2:0]       cnt_q;
   logic [2:0]       op_lat_q;
   logic             tok_valid_q, tok_is_op_q, ovf_q, drop_q;
   logic [WIDTH-1:0] tok_num_q;
   logic [2:0]       tok_op_q;

   logic       op_evt, dig_evt, xfer;
   logic [2:0] op_idx;
   logic [3:0] dig_idx;

   assign key_raw = {op_key, dig_key};

   // Synchronise, then accept a new level only after DB_CYCLES equal samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         flt_q   <= '0;
         evt_q   <= '0;
         for (int i = 0; i < NK; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < NK; i++) begin
            evt_q[i] <= 1'b0;
            if (sync2_q[i] == flt_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) begin
               flt_q[i]    <= sync2_q[i];
               db_cnt_q[i] <= '0;
               evt_q[i]    <= sync2_q[i];
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Lowest index wins within each group; operators outrank digits.
   always_comb begin
      op_idx  = '0;
      dig_idx = '0;
      for (int i = 7; i >= 0; i--) if (evt_q[10+i]) op_idx = 3'(i);
      for (int i = 9; i >= 0; i--) if (evt_q[i]) dig_idx = 4'(i);
   end

   assign op_evt  = |evt_q[17:10];
   assign dig_evt = |evt_q[9:0];
   assign xfer    = tok_valid_q & tok_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         value_q     <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         op_lat_q    <= '0;
         tok_valid_q <= 1'b0;
         tok_is_op_q <= 1'b0;
         tok_num_q   <= '0;
         tok_op_q    <= '0;
         ovf_q       <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         ovf_q  <= 1'b0;
         drop_q <= 1'b0;
         case (state_q)
            IDLE, ENTRY: begin
               if (op_evt) begin
                  tok_valid_q <= 1'b1;
                  if (state_q == IDLE) begin
                     tok_is_op_q <= 1'b1;
                     tok_op_q    <= op_idx;
                     state_q     <= SEND_OP;
                  end else begin
                     op_lat_q    <= op_idx;
                     tok_num_q   <= value_q;
                     tok_is_op_q <= 1'b0;
                     state_q     <= SEND_NUM;
                  end
               end else if (dig_evt) begin
                  if (cnt_q < 3'(MAX_DIGITS)) begin
                     value_q <= WIDTH'(MW'(value_q) * MW'(10) + MW'(dig_idx));
                     bcd_q   <= (bcd_q << 4) | BW'(dig_idx);
                     cnt_q   <= cnt_q + 3'd1;
                     state_q <= ENTRY;
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            SEND_NUM: begin
               drop_q <= op_evt | dig_evt;
               if (xfer) begin
                  tok_is_op_q <= 1'b1;
                  tok_op_q    <= op_lat_q;
                  value_q     <= '0;
                  bcd_q       <= '0;
                  cnt_q       <= '0;
                  state_q     <= SEND_OP;
               end
            end
            SEND_OP: begin
               drop_q <= op_evt | dig_evt;
               if (xfer) begin
                  tok_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tok_valid  = tok_valid_q;
   assign tok_is_op  = tok_is_op_q;
   assign tok_num    = tok_num_q;
   assign tok_op     = tok_op_q;
   assign entry_bcd  = bcd_q;
   assign entry_cnt  = cnt_q;
   assign ovf_pulse  = ovf_q;
   assign drop_pulse = drop_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry: key-press vector table plus handshake,
// glitch and reset sequences.
module tb_operand_entry;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  dig_key;
   logic [7:0]  op_key;
   logic        tok_valid, tok_ready, tok_is_op;
   logic [15:0] tok_num;
   logic [2:0]  tok_op;
   logic [15:0] entry_bcd;
   logic [2:0]  entry_cnt;
   logic        ovf_pulse, drop_pulse;

   operand_entry #(.WIDTH(16), .MAX_DIGITS(4), .DB_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .dig_key(dig_key), .op_key(op_key),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
      .tok_num(tok_num), .tok_op(tok_op), .entry_bcd(entry_bcd),
      .entry_cnt(entry_cnt), .ovf_pulse(ovf_pulse), .drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  dig;
      logic [7:0]  op;
      int          hold;
      int          exp_cnt;
      logic [15:0] exp_bcd;
      int          exp_ntok;
      logic        t0_is_op;
      int          t0_val;
      logic        t1_is_op;
      int          t1_val;
      int          exp_ovf;
   } vec_t;

   typedef struct {
      logic        is_op;
      logic [15:0] num;
      logic [2:0]  op;
   } tok_t;

   tok_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_ovf = 0;
   int   n_drop = 0;

   // Observe transfers and pulses halfway between rising edges.
   always @(negedge clk) begin
      if (!rst && tok_valid && tok_ready) q.push_back('{tok_is_op, tok_num, tok_op});
      if (ovf_pulse) n_ovf++;
      if (drop_pulse) n_drop++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_tok(input string name, input int idx, input logic is_op, input int val);
      if (q.size() > idx) begin
         check({name, "_is_op"}, 32'(q[idx].is_op), 32'(is_op));
         check({name, "_val"}, is_op ? 32'(q[idx].op) : 32'(q[idx].num), 32'(val));
      end else begin
         n_vec++;
         n_err++;
         $display("FAIL %s: token %0d missing, got %0d tokens", name, idx, q.size());
      end
   endtask

   task automatic press(input logic [9:0] d, input logic [7:0] o, input int hold);
      @(posedge clk); #1;
      dig_key = d;
      op_key  = o;
      repeat (hold) @(posedge clk);
      #1;
      dig_key = '0;
      op_key  = '0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [9:0] d, input logic [7:0] o, input int hold,
                               input int cnt, input logic [15:0] bcd, input int ntok,
                               input logic i0, input int v0, input logic i1, input int v1,
                               input int ovf);
      vec_t v;
      v.dig = d; v.op = o; v.hold = hold; v.exp_cnt = cnt; v.exp_bcd = bcd;
      v.exp_ntok = ntok; v.t0_is_op = i0; v.t0_val = v0; v.t1_is_op = i1;
      v.t1_val = v1; v.exp_ovf = ovf;
      return v;
   endfunction

   localparam int NV = 14;
   vec_t vecs[NV];

   initial begin
      int ovf0, drop0;
      vecs[0]  = mk(10'd1 << 2, 8'd0,   12, 1, 16'h0002, 0, 0, 0,    0, 0, 0);
      vecs[1]  = mk(10'd1 << 3, 8'd0,   12, 2, 16'h0023, 0, 0, 0,    0, 0, 0);
      vecs[2]  = mk(10'd0,      8'd1 << 2, 12, 0, 16'h0000, 2, 0, 23,   1, 2, 0);
      vecs[3]  = mk(10'd1 << 1, 8'd0,   12, 1, 16'h0001, 0, 0, 0,    0, 0, 0);
      vecs[4]  = mk(10'd1 << 2, 8'd0,   12, 2, 16'h0012, 0, 0, 0,    0, 0, 0);
      vecs[5]  = mk(10'd1 << 3, 8'd0,   12, 3, 16'h0123, 0, 0, 0,    0, 0, 0);
      vecs[6]  = mk(10'd1 << 4, 8'd0,   12, 4, 16'h1234, 0, 0, 0,    0, 0, 0);
      vecs[7]  = mk(10'd1 << 5, 8'd0,   12, 4, 16'h1234, 0, 0, 0,    0, 0, 1);
      vecs[8]  = mk(10'd0,      8'd1 << 7, 12, 0, 16'h0000, 2, 0, 1234, 1, 7, 0);
      vecs[9]  = mk((10'd1 << 3) | (10'd1 << 7), 8'd0, 12, 1, 16'h0003, 0, 0, 0, 0, 0, 0);
      vecs[10] = mk(10'd0,      8'd1,   12, 0, 16'h0000, 2, 0, 3,    1, 0, 0);
      vecs[11] = mk(10'd1 << 5, 8'd1,   12, 0, 16'h0000, 1, 1, 0,    0, 0, 0);
      vecs[12] = mk(10'd1 << 9, 8'd0,   20, 1, 16'h0009, 0, 0, 0,    0, 0, 0);
      vecs[13] = mk(10'd0,      8'd1 << 1, 12, 0, 16'h0000, 2, 0, 9,    1, 1, 0);

      rst = 1'b1;
      dig_key = '0;
      op_key = '0;
      tok_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(tok_valid), 0);
      check("rst_num", 32'(tok_num), 0);
      check("rst_cnt", 32'(entry_cnt), 0);
      check("rst_bcd", 32'(entry_bcd), 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         q.delete();
         ovf0  = n_ovf;
         drop0 = n_drop;
         press(vecs[i].dig, vecs[i].op, vecs[i].hold);
         check($sformatf("v%0d_cnt", i), 32'(entry_cnt), 32'(vecs[i].exp_cnt));
         check($sformatf("v%0d_bcd", i), 32'(entry_bcd), 32'(vecs[i].exp_bcd));
         check($sformatf("v%0d_ovf", i), 32'(n_ovf - ovf0), 32'(vecs[i].exp_ovf));
         check($sformatf("v%0d_drop", i), 32'(n_drop - drop0), 0);
         check($sformatf("v%0d_ntok", i), 32'(q.size()), 32'(vecs[i].exp_ntok));
         if (vecs[i].exp_ntok > 0) chk_tok($sformatf("v%0d_t0", i), 0, vecs[i].t0_is_op, vecs[i].t0_val);
         if (vecs[i].exp_ntok > 1) chk_tok($sformatf("v%0d_t1", i), 1, vecs[i].t1_is_op, vecs[i].t1_val);
      end

      // Three-cycle glitch on digit 9 must not register
      q.delete();
      @(posedge clk); #1;
      dig_key = 10'd1 << 9;
      repeat (3) @(posedge clk);
      #1;
      dig_key = '0;
      repeat (15) @(posedge clk);
      #1;
      check("glitch_cnt", 32'(entry_cnt), 0);
      check("glitch_ntok", 32'(q.size()), 0);

      // Back-pressure: 456 held stable, key during SEND_NUM dropped
      press(10'd1 << 4, 8'd0, 12);
      press(10'd1 << 5, 8'd0, 12);
      press(10'd1 << 6, 8'd0, 12);
      tok_ready = 1'b0;
      q.delete();
      drop0 = n_drop;
      press(10'd0, 8'd1 << 1, 12);
      check("bp_valid", 32'(tok_valid), 1);
      check("bp_is_op", 32'(tok_is_op), 0);
      check("bp_num", 32'(tok_num), 456);
      check("bp_cnt", 32'(entry_cnt), 3);
      check("bp_bcd", 32'(entry_bcd), 32'h456);
      press(10'd1 << 7, 8'd0, 10);
      check("bp_drop", 32'(n_drop - drop0), 1);
      check("bp_num_hold", 32'(tok_num), 456);
      check("bp_cnt_hold", 32'(entry_cnt), 3);
      tok_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("bp_ntok", 32'(q.size()), 2);
      chk_tok("bp_t0", 0, 1'b0, 456);
      chk_tok("bp_t1", 1, 1'b1, 1);
      check("bp_cnt_clr", 32'(entry_cnt), 0);
      check("bp_valid_clr", 32'(tok_valid), 0);

      // Asynchronous reset while an operand token is pending
      press(10'd1 << 8, 8'd0, 12);
      tok_ready = 1'b0;
      press(10'd0, 8'd1 << 3, 12);
      check("rs_pending", 32'(tok_valid), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rs_valid", 32'(tok_valid), 0);
      check("rs_num", 32'(tok_num), 0);
      check("rs_is_op", 32'(tok_is_op), 0);
      check("rs_op", 32'(tok_op), 0);
      check("rs_cnt", 32'(entry_cnt), 0);
      check("rs_bcd", 32'(entry_bcd), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      tok_ready = 1'b1;
      q.delete();
      repeat (20) @(posedge clk);
      #1;
      check("rs_ntok", 32'(q.size()), 0);

      // Recovery after reset
      press(10'd1 << 6, 8'd0, 12);
      press(10'd0, 8'd1 << 4, 12);
      check("rc_ntok", 32'(q.size()), 2);
      chk_tok("rc_t0", 0, 1'b0, 6);
      chk_tok("rc_t1", 1, 1'b1, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
